// File: rtl/alu_muldiv_sequencer.sv
// Iterative 32-cycle MUL / DIVU / REMU sequencer that borrows the shared
// combinational ALU for one add or subtract per cycle.
module alu_muldiv_sequencer #(
  parameter logic [3:0] ADD_OP = 4'd0,
  parameter logic [3:0] SUB_OP = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  alu_operation,
  output logic [31:0] alu_operand1,
  output logic [31:0] alu_operand2,
  input  logic [31:0] alu_result
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [4:0]  counter;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;

  logic [32:0] remshift;
  logic        take;
  logic [31:0] acc_next;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // Full 33-bit compare so divisors with bit 31 set are not misjudged
  // when the shifted remainder overflows 32 bits.
  function automatic logic div_fits(input logic [32:0] rs, input logic [31:0] d);
    return rs >= {1'b0, d};
  endfunction

  always_comb begin
    remshift      = {rem, quo[31]};
    take          = div_fits(remshift, dvsr);
    alu_operation = ADD_OP;
    alu_operand1  = 32'd0;
    alu_operand2  = 32'd0;
    if (state == RUN) begin
      if (op_q == OP_MUL) begin
        alu_operation = ADD_OP;
        alu_operand1  = acc;
        alu_operand2  = mcand;
      end else begin
        alu_operation = SUB_OP;
        alu_operand1  = remshift[31:0];
        alu_operand2  = dvsr;
      end
    end
    acc_next = mplier[0] ? alu_result : acc;
    rem_next = take ? alu_result : remshift[31:0];
    quo_next = {quo[30:0], take};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_MUL;
      counter <= 5'd0;
      acc     <= 32'd0;
      mcand   <= 32'd0;
      mplier  <= 32'd0;
      rem     <= 32'd0;
      quo     <= 32'd0;
      dvsr    <= 32'd0;
      result  <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            counter <= 5'd0;
            busy    <= 1'b1;
            if (op == OP_RSV) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= 32'd0;
            end else begin
              state  <= RUN;
              acc    <= 32'd0;
              mcand  <= operand1;
              mplier <= operand2;
              rem    <= 32'd0;
              quo    <= operand1;
              dvsr   <= operand2;
            end
          end
        end
        RUN: begin
          counter <= counter + 5'd1;
          if (op_q == OP_MUL) begin
            acc    <= acc_next;
            mcand  <= {mcand[30:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
          end else begin
            rem <= rem_next;
            quo <= quo_next;
          end
          if (counter == 5'd31) begin
            state <= DONE;
            done  <= 1'b1;
            case (op_q)
              OP_MUL:  result <= acc_next;
              OP_DIVU: result <= quo_next;
              OP_REMU: result <= rem_next;
              default: result <= 32'd0;
            endcase
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Randomised and directed checks of the MUL/DIVU/REMU sequencer against
// plain-arithmetic expectations, with a behavioural shared ALU.
module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  alu_operation;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [31:0] alu_result;

  int vectors;
  int miscompares;

  alu_muldiv_sequencer #(.ADD_OP(4'd0), .SUB_OP(4'd1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result),
    .alu_operation(alu_operation), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: 0 = add, 1 = subtract, anything else produces junk.
  always_comb begin
    case (alu_operation)
      4'd0:    alu_result = alu_operand1 + alu_operand2;
      4'd1:    alu_result = alu_operand1 - alu_operand2;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    case (o)
      2'b00:   return prod[31:0];
      2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one operation at a negedge and follow it edge by edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_start, input string name);
    logic [31:0] exp;
    int          n;
    logic [3:0]  exp_aluop;
    exp       = model(o, a, b);
    n         = (o == 2'b11) ? 0 : 32;
    exp_aluop = (o == 2'b00) ? 4'd0 : 4'd1;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    operand1 = a;
    operand2 = b;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    op       = 2'($urandom_range(0, 3));
    operand1 = $urandom;
    operand2 = $urandom;
    for (int k = 0; k <= n; k++) begin
      vectors++;
      if (busy !== 1'b1 || done !== (k == n)) begin
        miscompares++;
        $display("FAIL %s cycle %0d: busy=%b done=%b, want busy=1 done=%b", name, k, busy, done, (k == n));
      end
      if (k < n) begin
        vectors++;
        if (alu_operation !== exp_aluop) begin
          miscompares++;
          $display("FAIL %s alu_operation cycle %0d: got %0d want %0d", name, k, alu_operation, exp_aluop);
        end
      end else begin
        vectors++;
        if (result !== exp) begin
          miscompares++;
          $display("FAIL %s result at done: got %h want %h", name, result, exp);
        end
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== exp || alu_operation !== 4'd0 ||
        alu_operand1 !== 32'd0 || alu_operand2 !== 32'd0) begin
      miscompares++;
      $display("FAIL %s after done: busy=%b done=%b result=%h aluop=%0d, want 0 0 %h 0", name, busy, done, result, alu_operation, exp);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00; operand1 = 32'd0; operand2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || alu_operation !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b result=%h aluop=%0d, want 0", busy, done, result, alu_operation);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6, 0, "mul_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, "mul_wrap_ff");
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 0, "mul_wrap_zero");
  endtask

  task automatic test_div();
    run_op(2'b01, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(2'b10, 32'd100, 32'd7, 0, "remu_100_7");
    run_op(2'b01, 32'h1234, 32'd0, 0, "divu_by_zero");
    run_op(2'b10, 32'h1234, 32'd0, 0, "remu_by_zero");
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 0, "divu_big");
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 0, "remu_big");
  endtask

  task automatic test_control();
    run_op(2'b00, 32'd11, 32'd13, 1, "mul_start_held");
    run_op(2'b11, 32'hABCD, 32'h1, 0, "reserved_op");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 2));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = 32'h8000_0000 | $urandom;
        default: b = $urandom;
      endcase
      run_op(o, a, b, 0, "random");
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    start = 1'b1; op = 2'b01; operand1 = 32'd1000; operand2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset_mid_run: busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, 0, "mul_after_reset");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mul();
    test_div();
    test_control();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
- Iterative multiply/divide controller that owns the shared 32-bit combinational ALU for 32 cycles per operation.
- Each cycle it drives one ALU add/sub and folds the returned result into local accumulator/remainder registers.
- Sits beside the execute stage. The core issues MUL/DIVU/REMU via a start pulse and stalls on busy until done.

Parameters:
- ADD_OP, 4'd0, ALU operation code for addition; must match the shared ALU encoding.
- SUB_OP, 4'd1, ALU operation code for subtraction; must match the shared ALU encoding.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved
- operand1  input  32  multiplicand / dividend
- operand2  input  32  multiplier / divisor
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- result  output  32  final value; held until next accepted start
- alu_operation  output  4  operation code driven to the shared ALU
- alu_operand1  output  32  ALU operand 1
- alu_operand2  output  32  ALU operand 2
- alu_result  input  32  combinational ALU result, same cycle

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on port reset.
- Reset (async, any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0. The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a clock edge with start=1 (op 00/01/10):
  - Latch op and operands. Counter=0, busy=1.
  - MUL: acc=0, mcand=operand1, mplier=operand2.
  - DIV: rem=0, quo=operand1, dvsr=operand2.
- IDLE -> DONE on start=1 with op=11: result=0 next cycle, no ALU use.
- RUN, MUL, per edge:
  - ALU driven with ADD_OP, alu_operand1=acc, alu_operand2=mcand.
  - If mplier[0], acc<=alu_result; otherwise acc is unchanged.
  - mcand<<=1, mplier>>=1 (local shifts). Wrap mod 2^32.
- RUN, DIVU/REMU, per edge (restoring division):
  - Form 33-bit remshift={rem,quo[31]}.
  - ALU driven with SUB_OP, alu_operand1=remshift[31:0], alu_operand2=dvsr.
  - Local unsigned 33-bit compare remshift >= {1'b0,dvsr}.
    - If true: rem<=alu_result, quo<={quo[30:0],1}.
    - Else: rem<=remshift[31:0], quo<={quo[30:0],0}.
- Counter increments each RUN edge. On the edge where counter=31, go to DONE and load result:
  - MUL: acc value including the final add.
  - DIVU: quo.
  - REMU: rem.
- DONE: done=1 for exactly one cycle, busy=1. Next edge goes to IDLE, busy=0.
- Latency: the start edge is E0. done is high between E32 and E33. The next start is accepted at E33 or later.
- start is ignored while busy=1. operand and op changes during RUN are ignored (latched copies are used).
- Outside RUN: alu_operation=ADD_OP, alu_operand1=0, alu_operand2=0.
- Divide by zero needs no special case and must yield DIVU=32'hFFFFFFFF and REMU=dividend.
- The 33-bit compare is mandatory. Divisors >= 2^31 must be handled correctly.
- result holds its value through IDLE until the next DONE load.

Test Plan:
- MUL 7 x 6, start at E0 -> busy high E0..E33, done at E32 only, result=42.
- MUL 32'hFFFFFFFF x 2 -> result=32'hFFFFFFFE; MUL 32'h10000 x 32'h10000 -> result=0 (wrap).
- DIVU 100/7 -> 14; REMU 100/7 -> 2. During RUN, alu_operation=SUB_OP every cycle.
- Divide by zero: DIVU 32'h1234/0 -> 32'hFFFFFFFF; REMU 32'h1234/0 -> 32'h1234.
- Large divisor: DIVU 32'hFFFFFFFF/32'h80000001 -> 1; REMU of the same -> 32'h7FFFFFFE.
- Control corner cases:
  - start held high through busy -> only one operation runs.
  - op=11 -> done one cycle after start, result=0.
  - reset asserted mid-RUN (cycle 10) -> busy, done and result are 0 immediately, with no clock edge required.
  - A new MUL 3 x 5 after reset -> 15.
